// File: rtl/fuzzy_pkg.sv
// Shared constants for the fuzzy coprocessor MMIO map and the scheduler FSM.
package fuzzy_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_T      = 8'h02;
    localparam logic [7:0] ADDR_G      = 8'h04;

    localparam int CTRL_START    = 0;
    localparam int CTRL_REG_MODE = 1;
    localparam int CTRL_DT_MODE  = 2;
    localparam int CTRL_INIT     = 3;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_VALID = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECHK,
        ST_WR_T,
        ST_WR_INIT,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_G,
        ST_ACK
    } sched_state_t;

    function automatic logic [7:0] ctrl_word(input logic start, input logic reg_mode,
                                             input logic dt_mode, input logic init);
        logic [7:0] w;
        w                = '0;
        w[CTRL_START]    = start;
        w[CTRL_REG_MODE] = reg_mode;
        w[CTRL_DT_MODE]  = dt_mode;
        w[CTRL_INIT]     = init;
        return w;
    endfunction

endpackage

// File: rtl/fuzzy_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int cand;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_CH) cand = cand - N_CH;
            if (!any && req[IDX_W'(cand)]) begin
                any                           = 1'b1;
                grant_idx                     = IDX_W'(cand);
                grant_onehot[IDX_W'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fuzzy_sched.sv
// Shares one fuzzy coprocessor between N_CH requesters: arbitrate, write T and
// CTRL over MMIO, poll STATUS, read G and hand it back with a one-cycle ack.
module fuzzy_sched
    import fuzzy_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int TIMEOUT = 64,
    parameter  int RD_LAT  = 1,
    localparam int IDX_W   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_reg_mode,
    input  logic              cfg_dt_mode,
    input  logic [N_CH-1:0]   ch_req,
    input  logic [N_CH*8-1:0] ch_T,
    output logic [N_CH-1:0]   ch_ack,
    output logic [7:0]        res_G,
    output logic [IDX_W-1:0]  res_ch,
    output logic              res_err,
    output logic              sched_busy,
    output logic              cs,
    output logic              wr,
    output logic              rd,
    output logic [7:0]        addr,
    output logic [7:0]        wdata,
    input  logic [7:0]        rdata
);

    localparam int         CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    sched_state_t     state;
    logic [1:0]       lat_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [IDX_W-1:0] cur_ch;
    logic [7:0]       cur_T;
    logic             cur_reg;
    logic             cur_dt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] last_ch;
    logic             last_valid;

    logic [N_CH-1:0]  arb_onehot;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [7:0]       sel_T;
    logic             read_done;
    logic             tmo_hit;
    logic             need_init;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req          (ch_req),
        .ptr          (rr_ptr),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any          (arb_any)
    );

    always_comb begin
        sel_T = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_onehot[i]) sel_T = sel_T | ch_T[8*i +: 8];
        end
    end

    // A read is one strobe cycle followed by RD_LAT wait cycles; rdata is taken on the last.
    assign read_done  = (lat_cnt == LAT_LAST);
    assign tmo_hit    = (int'(tmo_cnt) + 1) >= TIMEOUT;
    assign need_init  = cur_dt && (!last_valid || (last_ch != cur_ch));
    assign next_ptr   = (int'(cur_ch) == N_CH - 1) ? '0 : cur_ch + IDX_W'(1);
    assign sched_busy = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            tmo_cnt    <= '0;
            cur_ch     <= '0;
            cur_T      <= '0;
            cur_reg    <= 1'b0;
            cur_dt     <= 1'b0;
            rr_ptr     <= '0;
            last_ch    <= '0;
            last_valid <= 1'b0;
            res_G      <= '0;
            res_ch     <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && arb_any) begin
                        cur_ch  <= arb_idx;
                        cur_T   <= sel_T;
                        cur_reg <= cfg_reg_mode;
                        cur_dt  <= cfg_dt_mode;
                        lat_cnt <= '0;
                        state   <= ST_PRECHK;
                    end
                end
                ST_PRECHK: begin
                    if (read_done) begin
                        lat_cnt <= '0;
                        if (!rdata[STATUS_BUSY]) state <= ST_WR_T;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_WR_T: begin
                    state <= need_init ? ST_WR_INIT : ST_WR_CTRL;
                end
                ST_WR_INIT: begin
                    state <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    tmo_cnt <= '0;
                    lat_cnt <= '0;
                    state   <= ST_POLL;
                end
                ST_POLL: begin
                    if (int'(tmo_cnt) < TIMEOUT) tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (read_done) begin
                        lat_cnt <= '0;
                        if (rdata[STATUS_VALID]) begin
                            state <= ST_RD_G;
                        end else if (tmo_hit) begin
                            res_G   <= '0;
                            res_err <= 1'b1;
                            res_ch  <= cur_ch;
                            state   <= ST_ACK;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_RD_G: begin
                    if (read_done) begin
                        lat_cnt <= '0;
                        res_G   <= rdata;
                        res_err <= 1'b0;
                        res_ch  <= cur_ch;
                        state   <= ST_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_ACK: begin
                    rr_ptr     <= next_ptr;
                    last_ch    <= cur_ch;
                    last_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        cs    = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;
        case (state)
            ST_PRECHK, ST_POLL: begin
                if (lat_cnt == 2'd0) begin
                    cs   = 1'b1;
                    rd   = 1'b1;
                    addr = ADDR_STATUS;
                end
            end
            ST_WR_T: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = ADDR_T;
                wdata = cur_T;
            end
            ST_WR_INIT: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = ADDR_CTRL;
                wdata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            ST_WR_CTRL: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = ADDR_CTRL;
                wdata = ctrl_word(1'b1, cur_reg, cur_dt, 1'b0);
            end
            ST_RD_G: begin
                if (lat_cnt == 2'd0) begin
                    cs   = 1'b1;
                    rd   = 1'b1;
                    addr = ADDR_G;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ch_ack = '0;
        if (state == ST_ACK) ch_ack[cur_ch] = 1'b1;
    end

endmodule

// File: tb/tb_fuzzy_sched.sv
// Scoreboard bench for fuzzy_sched with a behavioural coprocessor model on the MMIO port.
module tb_fuzzy_sched;

    localparam int N_CH    = 4;
    localparam int TIMEOUT = 64;
    localparam int RD_LAT  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              cfg_reg_mode = 1'b0;
    logic              cfg_dt_mode = 1'b0;
    logic [N_CH-1:0]   ch_req = '0;
    logic [N_CH*8-1:0] ch_T = '0;
    logic [N_CH-1:0]   ch_ack;
    logic [7:0]        res_G;
    logic [1:0]        res_ch;
    logic              res_err;
    logic              sched_busy;
    logic              cs, wr, rd;
    logic [7:0]        addr, wdata;
    logic [7:0]        rdata = '0;

    always #5 clk = ~clk;

    fuzzy_sched #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_reg_mode (cfg_reg_mode),
        .cfg_dt_mode  (cfg_dt_mode),
        .ch_req       (ch_req),
        .ch_T         (ch_T),
        .ch_ack       (ch_ack),
        .res_G        (res_G),
        .res_ch       (res_ch),
        .res_err      (res_err),
        .sched_busy   (sched_busy),
        .cs           (cs),
        .wr           (wr),
        .rd           (rd),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata)
    );

    typedef struct {
        int         ch;
        logic [7:0] g;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] wr_q[$];
    int          pending[N_CH];
    logic [7:0]  tval[N_CH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Coprocessor model: G = clamp(signed T + 50, 0..100); valid m_lat edges after start.
    logic m_busy = 1'b0, m_valid = 1'b0, m_stuck = 1'b0;
    int   m_cnt = 0;
    int   m_lat = 3;
    logic [7:0] m_T = '0, m_G = '0;

    function automatic logic [7:0] g_of(input logic [7:0] t);
        int v;
        v = int'($signed(t)) + 50;
        if (v < 0) v = 0;
        if (v > 100) v = 100;
        return 8'(v);
    endfunction

    always @(posedge clk) begin
        if (cs && wr && addr == 8'h02) m_T <= wdata;
        if (cs && wr && addr == 8'h00 && wdata[0]) begin
            m_busy  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= m_lat;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy  <= 1'b0;
                m_valid <= !m_stuck;
                m_G     <= g_of(m_T);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (cs && rd) begin
            case (addr)
                8'h01:   rdata <= {6'b0, m_valid, m_busy};
                8'h04:   rdata <= m_G;
                default: rdata <= 8'h00;
            endcase
        end
    end

    // Monitor and requester driver: scoreboard compares on ack and on every MMIO write.
    initial begin
        exp_t e;
        for (int i = 0; i < N_CH; i++) begin
            pending[i] = 0;
            tval[i]    = '0;
        end
        forever begin
            @(negedge clk);
            if (ch_ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 64'(ch_ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_onehot", 64'(ch_ack), 64'(1 << e.ch));
                    check("res_ch", 64'(res_ch), 64'(e.ch));
                    check("res_G", 64'(res_G), 64'(e.g));
                    check("res_err", 64'(res_err), 64'(e.err));
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_ack[i] && pending[i] > 0) pending[i]--;
                end
            end
            if (cs && wr) begin
                if (wr_q.size() == 0) check("wr_unexpected", {48'd0, addr, wdata}, 64'd0);
                else check("mmio_wr", {48'd0, addr, wdata}, 64'(wr_q.pop_front()));
                check("wr_while_busy", 64'(m_busy), 64'd0);
            end
            if (wr || rd) check("strobe_ok", {62'd0, cs, wr & rd}, 64'd2);
            for (int i = 0; i < N_CH; i++) begin
                ch_req[i]        = (pending[i] > 0);
                ch_T[8*i +: 8]   = tval[i];
            end
        end
    end

    task automatic request(input int ch, input logic [7:0] t, input logic [7:0] g, input logic err);
        exp_t e;
        tval[ch] = t;
        pending[ch]++;
        e.ch  = ch;
        e.g   = g;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sched_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) bound_expired(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_wr(input string name, input logic [7:0] a, input int budget);
        int n;
        n = 0;
        while (!(cs && wr && addr == a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) bound_expired(name);
    endtask

    initial begin
        int n;
        int t0;
        int busy_reads;

        // Reset state
        @(negedge clk);
        #1;
        check("reset_outputs",
              {29'd0, cs, wr, rd, ch_ack, sched_busy, res_G, res_ch, res_err, addr, wdata}, 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        // 1: single request on ch1, plus grant-to-ack latency
        exp_wr(8'h02, 8'h14);
        exp_wr(8'h00, 8'h01);
        request(1, 8'h14, 8'd70, 1'b0);
        n = 0;
        while (!sched_busy && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        n  = 0;
        while (ch_ack == '0 && n < 100) begin @(negedge clk); n++; end
        check("grant_to_ack", 64'(cyc - t0), 64'd12);
        drain("t1_drain", 200);

        // 2: all channels from reset, ch0 twice -> 0,1,2,3,0
        do_reset();
        request(0, 8'h00, 8'd50, 1'b0);
        request(1, 8'hEC, 8'd30, 1'b0);
        request(2, 8'h50, 8'd100, 1'b0);
        request(3, 8'h9C, 8'd0, 1'b0);
        request(0, 8'h00, 8'd50, 1'b0);
        exp_wr(8'h02, 8'h00); exp_wr(8'h00, 8'h01);
        exp_wr(8'h02, 8'hEC); exp_wr(8'h00, 8'h01);
        exp_wr(8'h02, 8'h50); exp_wr(8'h00, 8'h01);
        exp_wr(8'h02, 8'h9C); exp_wr(8'h00, 8'h01);
        exp_wr(8'h02, 8'h00); exp_wr(8'h00, 8'h01);
        drain("t2_drain", 400);

        // 3: dt_mode init only on channel change
        do_reset();
        cfg_dt_mode  = 1'b1;
        cfg_reg_mode = 1'b1;
        request(2, 8'h2D, 8'd95, 1'b0);
        request(2, 8'h2D, 8'd95, 1'b0);
        exp_wr(8'h02, 8'h2D); exp_wr(8'h00, 8'h08); exp_wr(8'h00, 8'h07);
        exp_wr(8'h02, 8'h2D); exp_wr(8'h00, 8'h07);
        drain("t3a_drain", 300);
        request(3, 8'hF6, 8'd40, 1'b0);
        exp_wr(8'h02, 8'hF6); exp_wr(8'h00, 8'h08); exp_wr(8'h00, 8'h07);
        drain("t3b_drain", 200);
        cfg_dt_mode  = 1'b0;
        cfg_reg_mode = 1'b0;

        // 4: timeout, then a normal transaction
        m_stuck = 1'b1;
        request(0, 8'h0A, 8'd0, 1'b1);
        exp_wr(8'h02, 8'h0A); exp_wr(8'h00, 8'h01);
        n = 0;
        while (!(cs && wr && addr == 8'h00 && wdata[0]) && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
        n  = 0;
        while (ch_ack == '0 && n < 200) begin @(negedge clk); n++; end
        check("timeout_window", 64'((cyc - t0) >= TIMEOUT && (cyc - t0) <= TIMEOUT + 4), 64'd1);
        drain("t4a_drain", 50);
        m_stuck = 1'b0;
        request(1, 8'h14, 8'd70, 1'b0);
        exp_wr(8'h02, 8'h14); exp_wr(8'h00, 8'h01);
        drain("t4b_drain", 200);

        // 5: async reset during POLL while the coprocessor is still busy
        m_lat = 40;
        request(2, 8'h1E, 8'd80, 1'b0);
        exp_wr(8'h02, 8'h1E); exp_wr(8'h00, 8'h01);
        exp_wr(8'h02, 8'h1E); exp_wr(8'h00, 8'h01);
        wait_wr("t5_start", 8'h00, 50);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop_reset_outputs",
              {29'd0, cs, wr, rd, ch_ack, sched_busy, res_G, res_ch, res_err, addr, wdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        m_lat = 3;
        busy_reads = 0;
        n = 0;
        while (!(cs && wr && addr == 8'h02) && n < 200) begin
            if (cs && rd && addr == 8'h01 && m_busy) busy_reads++;
            @(negedge clk);
            n++;
        end
        check("prechk_saw_busy", 64'(busy_reads > 0), 64'd1);
        drain("t5_drain", 300);

        // 6: enable dropped mid-transaction; ch0 waits; ch1 drop-before-grant ignored
        request(3, 8'h00, 8'd50, 1'b0);
        exp_wr(8'h02, 8'h00); exp_wr(8'h00, 8'h01);
        wait_wr("t6_wr_t", 8'h02, 50);
        enable = 1'b0;
        request(0, 8'hF1, 8'd35, 1'b0);
        n = 0;
        while (exp_q.size() > 1 && n < 100) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        check("no_grant_when_disabled", 64'(sched_busy), 64'd0);
        check("ch0_still_waiting", 64'(exp_q.size()), 64'd1);
        pending[1] = 1;
        repeat (3) @(negedge clk);
        pending[1] = 0;
        exp_wr(8'h02, 8'hF1); exp_wr(8'h00, 8'h01);
        @(negedge clk);
        enable = 1'b1;
        drain("t6_drain", 200);
        repeat (10) @(negedge clk);
        check("dropped_req_ignored", 64'(sched_busy), 64'd0);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, want completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
